// File: rtl/inst_loader.sv
// Per-column instruction memories with a stream loader and a PC-driven fetch stage.
// Loads a program image beat-by-beat into each column, then serves imem[c][PC_c] with one cycle of latency.

module inst_col #(
  parameter int DW    = 32,
  parameter int PW    = 512,
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int RW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] wrow,
  input  logic [PW-1:0] wdata,
  input  logic          pc_clr,
  input  logic          run,
  input  logic          clken,
  input  logic          load,
  input  logic          incr,
  input  logic [AW-1:0] load_value,
  input  logic          rd_en,
  output logic [DW-1:0] instr
);
  localparam int WPB  = PW / DW;
  localparam int ROWS = DEPTH / WPB;
  localparam int WI   = $clog2(WPB);

  // One memory row holds exactly one stream beat, so a beat is a single row write.
  logic [WPB-1:0][DW-1:0] mem [ROWS];
  logic [AW-1:0]          pc;

  always_ff @(posedge clk) begin
    if (we) mem[wrow] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (pc_clr) begin
      pc <= '0;
    end else if (run && clken) begin
      if (load)      pc <= load_value;
      else if (incr) pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instr <= '0;
    else     instr <= rd_en ? mem[pc[AW-1:WI]][pc[WI-1:0]] : '0;
  end
endmodule

module inst_loader #(
  parameter int dwidth_inst = 32,
  parameter int num_col     = 2,
  parameter int phit_size   = 512,
  parameter int imem_depth  = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ap_start,
  input  logic                           ap_done,
  input  logic [phit_size-1:0]           tdata_stream_in,
  input  logic                           tvalid_stream_in,
  output logic                           tready_stream_in,
  input  logic                           tlast_stream_in,
  output logic                           done_loader,
  output logic [dwidth_inst*num_col-1:0] instr,
  input  logic [num_col-1:0]             clken_PC,
  input  logic [num_col-1:0]             load_PC,
  input  logic [num_col-1:0]             incr_PC,
  input  logic [num_col*12-1:0]          load_value_PC,
  output logic                           loader_err
);
  localparam int AW  = $clog2(imem_depth);
  localparam int WPB = phit_size / dwidth_inst;
  localparam int RW  = $clog2(imem_depth / WPB);
  localparam int CW  = $clog2(num_col + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_t;
  state_t state, state_nxt;

  // Write pointer kept in beat rows; word address = wrow_ptr*WPB, top bit marks a full memory.
  logic [RW:0]   wrow_ptr;
  logic [CW-1:0] col_cnt;
  logic          accept, last_col, run, rd_en;

  assign accept   = (state == LOAD) && tvalid_stream_in;
  assign last_col = (col_cnt == CW'(num_col - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ap_start) state_nxt = LOAD;
      LOAD: if (accept && tlast_stream_in && last_col) state_nxt = DONE;
      DONE: state_nxt = RUN;
      RUN:  if (ap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tready_stream_in = (state == LOAD);
    done_loader      = (state == DONE);
    run              = (state == RUN);
    rd_en            = run && !ap_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrow_ptr   <= '0;
      col_cnt    <= '0;
      loader_err <= 1'b0;
    end else if (state == IDLE && ap_start) begin
      wrow_ptr   <= '0;
      col_cnt    <= '0;
      loader_err <= 1'b0;
    end else if (accept) begin
      // A beat beyond the end of memory is swallowed; the pointer saturates.
      if (wrow_ptr[RW]) loader_err <= 1'b1;
      else              wrow_ptr   <= wrow_ptr + 1'b1;
      if (tlast_stream_in) begin
        col_cnt  <= col_cnt + 1'b1;
        wrow_ptr <= '0;
      end
    end
  end

  for (genvar c = 0; c < num_col; c++) begin : g_col
    logic [dwidth_inst-1:0] col_instr;

    inst_col #(
      .DW(dwidth_inst), .PW(phit_size), .DEPTH(imem_depth), .AW(AW), .RW(RW)
    ) u_col (
      .clk        (clk),
      .rst        (rst),
      .we         (accept && !wrow_ptr[RW] && (col_cnt == CW'(c))),
      .wrow       (wrow_ptr[RW-1:0]),
      .wdata      (tdata_stream_in),
      .pc_clr     (done_loader),
      .run        (run),
      .clken      (clken_PC[c]),
      .load       (load_PC[c]),
      .incr       (incr_PC[c]),
      .load_value (load_value_PC[c*AW +: AW]),
      .rd_en      (rd_en),
      .instr      (col_instr)
    );

    assign instr[c*dwidth_inst +: dwidth_inst] = col_instr;
  end
endmodule

// File: tb/tb_inst_loader.sv
// Randomized scoreboard bench for inst_loader: a behavioural model predicts every cycle's
// outputs into a queue, and an independent monitor compares them against the DUT.

module tb_inst_loader;
  localparam int NC = 2;
  localparam int DEPTH = 4096;

  logic           clk, rst, ap_start, ap_done;
  logic [511:0]   tdata;
  logic           tvalid, tready, tlast, done_loader, loader_err;
  logic [63:0]    instr;
  logic [NC-1:0]  clken, load, incr;
  logic [23:0]    load_value;

  inst_loader dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .ap_done(ap_done),
    .tdata_stream_in(tdata), .tvalid_stream_in(tvalid), .tready_stream_in(tready),
    .tlast_stream_in(tlast), .done_loader(done_loader), .instr(instr),
    .clken_PC(clken), .load_PC(load), .incr_PC(incr), .load_value_PC(load_value),
    .loader_err(loader_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        tready;
    logic        done;
    logic        err;
    logic [63:0] instr;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  bit   stim_done = 0;

  // Behavioural model: program phase, per-column PC and a word-addressed memory image.
  localparam int P_IDLE = 0, P_LOAD = 1, P_DONE = 2, P_RUN = 3;
  int          ph, col_m, wa_m;
  int          pc_m [NC];
  int          lim [NC];
  bit          err_m;
  logic [63:0] ins_m;
  logic [31:0] mm [NC][DEPTH];

  task automatic model_edge();
    logic [63:0] ni;
    if (rst) begin
      ph = P_IDLE; col_m = 0; wa_m = 0; err_m = 0; ins_m = '0;
      for (int c = 0; c < NC; c++) pc_m[c] = 0;
      return;
    end
    ni = '0;
    if (ph == P_RUN && !ap_done)
      for (int c = 0; c < NC; c++) ni[c*32 +: 32] = mm[c][pc_m[c]];
    case (ph)
      P_IDLE: if (ap_start) begin ph = P_LOAD; col_m = 0; wa_m = 0; err_m = 0; end
      P_LOAD: if (tvalid) begin
        if (wa_m >= DEPTH) err_m = 1;
        else begin
          for (int k = 0; k < 16; k++) mm[col_m][wa_m + k] = tdata[k*32 +: 32];
          wa_m += 16;
          if (wa_m > lim[col_m]) lim[col_m] = wa_m;
        end
        if (tlast) begin
          col_m++; wa_m = 0;
          if (col_m == NC) ph = P_DONE;
        end
      end
      P_DONE: begin
        ph = P_RUN;
        for (int c = 0; c < NC; c++) pc_m[c] = 0;
      end
      default: begin
        for (int c = 0; c < NC; c++)
          if (clken[c]) begin
            if (load[c])      pc_m[c] = int'(load_value[c*12 +: 12]);
            else if (incr[c]) pc_m[c] = (pc_m[c] + 1) % DEPTH;
          end
        if (ap_done) ph = P_IDLE;
      end
    endcase
    ins_m = ni;
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e.tready = (ph == P_LOAD);
    e.done   = (ph == P_DONE);
    e.err    = err_m;
    e.instr  = ins_m;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [31:0] base, input bit rnd, input bit last);
    for (int k = 0; k < 16; k++) tdata[k*32 +: 32] = rnd ? $urandom : base + k;
    tvalid = 1'b1;
    tlast  = last;
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic start_load();
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NC; c++) begin
        clken[c] = $urandom_range(0, 3) != 0;
        load[c]  = $urandom_range(0, 5) == 0;
        incr[c]  = $urandom_range(0, 1);
        load_value[c*12 +: 12] = 12'($urandom_range(0, lim[c] - 1));
        // Keep fetches inside the region this bench has written.
        if (!load[c] && lim[c] < DEPTH && pc_m[c] + 1 >= lim[c]) incr[c] = 1'b0;
      end
      step();
    end
    clken = '0; load = '0; incr = '0;
  endtask

  task automatic finish_run();
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    step();
    step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (tready !== e.tready) begin
          miscompares++;
          $display("FAIL tready @%0t: got %b want %b", $time, tready, e.tready);
        end
        if (done_loader !== e.done) begin
          miscompares++;
          $display("FAIL done_loader @%0t: got %b want %b", $time, done_loader, e.done);
        end
        if (loader_err !== e.err) begin
          miscompares++;
          $display("FAIL loader_err @%0t: got %b want %b", $time, loader_err, e.err);
        end
        if (instr !== e.instr) begin
          miscompares++;
          $display("FAIL instr @%0t: got %h want %h", $time, instr, e.instr);
        end
      end
      if (stim_done && q.size() == 0) begin
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, want completion within time limit");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b1; ap_start = 0; ap_done = 0; tdata = '0; tvalid = 0; tlast = 0;
    clken = '0; load = '0; incr = '0; load_value = '0;
    for (int c = 0; c < NC; c++) lim[c] = 0;
    step();
    step();
    rst = 1'b0;
    step();

    // Small image: 2 beats to column 0, 1 beat to column 1.
    start_load();
    beat(32'h0000_0013, 0, 0);
    beat(32'h0000_0023, 0, 1);
    beat(32'h0010_0093, 0, 1);
    step();
    step();
    clken = 2'b01; incr = 2'b01;
    repeat (5) step();
    load = 2'b01; load_value = 24'h000_010;
    step();
    clken = '0; load = '0; incr = '0;
    step();
    run_rand(30);
    finish_run();

    // Overflow image: 257 beats to column 0 with gapped tvalid, 3 beats to column 1.
    start_load();
    n = 0;
    while (n < 257) begin
      tvalid = $urandom_range(0, 1);
      tlast  = tvalid ? (n == 256) : $urandom_range(0, 1);
      for (int k = 0; k < 16; k++) tdata[k*32 +: 32] = $urandom;
      step();
      if (tvalid) n++;
    end
    tvalid = 0; tlast = 0;
    beat(0, 1, 0);
    beat(0, 1, 0);
    beat(0, 1, 1);
    step();
    clken = 2'b01; load = 2'b01; load_value = 24'h000_ffe;
    step();
    load = 2'b00; incr = 2'b01;
    repeat (3) step();
    clken = '0; incr = '0;
    step();
    run_rand(200);
    finish_run();

    // Reset in the middle of a load, then a clean reload.
    start_load();
    beat(0, 1, 0);
    beat(0, 1, 0);
    beat(0, 1, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    start_load();
    beat(0, 1, 1);
    beat(0, 1, 1);
    step();
    run_rand(20);
    finish_run();

    stim_done = 1;
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Per-column instruction memory and fetch stage that sits directly upstream of data_path.
- Load phase: receives a program image over a 512-bit AXI-stream and writes it into num_col private instruction memories, then pulses done_loader.
- Run phase: each column's PC is driven by data_path's clken_PC/load_PC/incr_PC/load_value_PC. The stage returns the addressed instruction on the packed instr vector.

Parameters:
dwidth_inst, 32, instruction word width
num_col, 2, number of columns / instruction memories
phit_size, 512, stream beat width; words per beat = phit_size/dwidth_inst = 16
imem_depth, 4096, words per column memory; PC width = 12

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ap_start  in  1  begin a program load (level, sampled in IDLE)
ap_done  in  1  from data_path; ends RUN
tdata_stream_in  in  phit_size  program beat
tvalid_stream_in  in  1  beat valid
tready_stream_in  out  1  beat accepted when tvalid&tready
tlast_stream_in  in  1  last beat of current column's segment
done_loader  out  1  one-cycle pulse, all columns loaded
instr  out  dwidth_inst*num_col  column c's instruction in bits [(c+1)*dwidth_inst-1 : c*dwidth_inst]
clken_PC  in  num_col  per-column PC clock enable
load_PC  in  num_col  per-column PC load
incr_PC  in  num_col  per-column PC increment
load_value_PC  in  num_col*12  per-column PC load value
loader_err  out  1  sticky overflow flag

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - tready_stream_in=0, done_loader=0, instr=0, loader_err=0.
  - All PCs=0; column counter and word address = 0.
  - Memory contents are not cleared.
- States: IDLE -> LOAD -> DONE -> RUN -> IDLE.
- IDLE: tready_stream_in=0, instr=0. ap_start=1 moves to LOAD, clears col_cnt, waddr and loader_err.
- LOAD:
  - tready_stream_in=1 combinationally in this state.
  - Each accepted beat writes word k (bits [k*32+31:k*32], k=0..15) to imem[col_cnt][waddr+k]; waddr += 16.
  - tkeep is not used; all 16 words are written.
  - On an accepted beat with tlast=1: col_cnt++ and waddr=0. If col_cnt was num_col-1, go to DONE.
  - Overflow: a beat arriving with waddr==imem_depth is accepted and dropped, and loader_err is set (sticky until next ap_start).
  - waddr saturates at imem_depth; it never wraps.
- DONE: done_loader=1 for exactly one cycle; all PCs forced to 0; next state RUN.
- RUN, per column c, on a clk edge with clken_PC[c]=1:
  - load_PC[c]=1: PC <= load_value_PC[c*12+:12]. Load has priority over incr.
  - else incr_PC[c]=1: PC <= PC+1, wrapping 4095 -> 0.
  - else PC holds.
  - With clken_PC[c]=0, PC holds regardless of load/incr.
- Instruction output:
  - instr[c] is the registered read imem[c][PC_c], with one cycle of read latency after the PC update. A PC change at edge n gives the new word at edge n+1.
  - The first valid word (imem[c][0]) appears 1 cycle after entering RUN.
  - tready_stream_in=0 throughout RUN.
- ap_done=1 in RUN moves to IDLE next edge; instr returns to 0.
- ap_start is ignored outside IDLE. ap_done is ignored outside RUN.
- Stream beats in IDLE/DONE/RUN are not accepted.
- Reset mid-LOAD: partial image stays in memory; the next load starts again at column 0, address 0.
- Columns are independent; simultaneous control on all columns is legal.

Test Plan:
- Load 2 beats to col0 (words 0x00000013+i, tlast on beat 2), then 1 beat to col1 (0x00100093+i, tlast) -> done_loader pulses once, 1 cycle after the final handshake. In RUN, cycle 1: instr[31:0]=0x00000013, instr[63:32]=0x00100093.
- RUN, col0 clken=1, incr=1 for 5 cycles -> instr[31:0] steps 0x13, 0x14, ... 0x18, each lagging the PC by 1 cycle. Col1 with clken=0 stays 0x00100093.
- load_PC and incr_PC both high, load_value=12'h010, col0 -> PC=0x010 (load wins); next cycle instr[31:0]=imem[0][16]=0x00000023.
- Toggle tvalid 1/0 during LOAD -> only handshaked beats advance waddr. 257 beats to col0 -> beat 257 dropped, loader_err=1, still reaches DONE after col1 tlast.
- PC=4095 with incr -> PC=0, instr=imem[c][0]. ap_done=1 -> IDLE, instr=0, tready stays 0.
- Assert rst 3 beats into LOAD -> outputs at reset values immediately. New ap_start reload -> done_loader pulses once; no loader_err.
